// File: rtl/bit_entry_debounce.sv
// Push-button bit entry with debouncing.
// Both raw inputs are synchronized. The button runs through a four-state
// debounce FSM that issues one strobe per accepted press. The data switch
// is filtered by a stable-sample counter. Each strobe latches the filtered
// switch level as a new bit and advances a wrapping press counter.
module bit_entry_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       sw_raw,
  input  logic       clear,
  output logic       data,
  output logic       trig,
  output logic       pressed,
  output logic [7:0] press_cnt
);

  // Terminal count: a level must hold for DB_CYCLES synchronized samples.
  localparam logic [15:0] LP_LAST = 16'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic        r_btn_meta;
  logic        r_btn_s;
  logic        r_sw_meta;
  logic        r_sw_s;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic        w_trig_next;
  logic        w_pressed_next;

  logic        r_sw_db;
  logic        w_sw_db_next;
  logic [15:0] r_sw_cnt;
  logic [15:0] w_sw_cnt_next;

  logic        r_data;
  logic        r_trig;
  logic        r_pressed;
  logic [7:0]  r_press_cnt;

  // Two-flop synchronizers for the asynchronous button and switch levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
      r_sw_meta  <= 1'b0;
      r_sw_s     <= 1'b0;
    end else begin
      r_btn_meta <= btn_raw;
      r_btn_s    <= r_btn_meta;
      r_sw_meta  <= sw_raw;
      r_sw_s     <= r_sw_meta;
    end
  end

  // Button FSM next-state, counter and strobe decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_trig_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_btn_s) begin
          w_state_next = PRESS_WAIT;
          w_cnt_next   = 16'd1;
        end
      end
      PRESS_WAIT: begin
        if (!r_btn_s) begin
          // Bounce during the press window: abandon without a strobe.
          w_state_next = IDLE;
          w_cnt_next   = 16'd0;
        end else if (r_cnt == LP_LAST) begin
          w_state_next = PRESSED;
          w_cnt_next   = 16'd0;
          w_trig_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      PRESSED: begin
        if (!r_btn_s) begin
          w_state_next = RELEASE_WAIT;
          w_cnt_next   = 16'd1;
        end
      end
      RELEASE_WAIT: begin
        if (r_btn_s) begin
          // Bounce during release: back to PRESSED, no new strobe.
          w_state_next = PRESSED;
          w_cnt_next   = 16'd0;
        end else if (r_cnt == LP_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = 16'd0;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 16'd0;
      end
    endcase
    w_pressed_next = (w_state_next == PRESSED) || (w_state_next == RELEASE_WAIT);
  end

  // Button FSM state and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Switch filter: accept a new level only after DB_CYCLES differing samples.
  always_comb begin
    w_sw_db_next  = r_sw_db;
    w_sw_cnt_next = 16'd0;
    if (r_sw_s != r_sw_db) begin
      if (r_sw_cnt == LP_LAST) begin
        w_sw_db_next  = r_sw_s;
        w_sw_cnt_next = 16'd0;
      end else begin
        w_sw_cnt_next = r_sw_cnt + 16'd1;
      end
    end
  end

  // Switch filter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_db  <= 1'b0;
      r_sw_cnt <= 16'd0;
    end else begin
      r_sw_db  <= w_sw_db_next;
      r_sw_cnt <= w_sw_cnt_next;
    end
  end

  // Output registers: strobe, latched bit, pressed level and press counter.
  // The bit takes the filtered switch level from before the strobe edge;
  // clear wins over a simultaneous strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_trig      <= 1'b0;
      r_data      <= 1'b0;
      r_pressed   <= 1'b0;
      r_press_cnt <= 8'd0;
    end else begin
      r_trig    <= w_trig_next;
      r_pressed <= w_pressed_next;
      if (w_trig_next) begin
        r_data <= r_sw_db;
      end
      if (clear) begin
        r_press_cnt <= 8'd0;
      end else if (w_trig_next) begin
        r_press_cnt <= r_press_cnt + 8'd1;
      end
    end
  end

  assign data      = r_data;
  assign trig      = r_trig;
  assign pressed   = r_pressed;
  assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_bit_entry_debounce.sv
// Bench for bit_entry_debounce with DB_CYCLES=4. Each expected strobe
// (bit value, press count, arrival cycle) is queued when the press is driven
// and checked by a monitor when trig appears.
module tb_bit_entry_debounce;

  localparam int unsigned DB = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic       sw_raw;
  logic       clear;
  logic       data;
  logic       trig;
  logic       pressed;
  logic [7:0] press_cnt;

  typedef struct {
    logic        d;
    logic [7:0]  c;
    int unsigned at;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks;
  int          errors;
  int unsigned cyc;
  logic        prev_trig;
  logic [7:0]  model_cnt;

  bit_entry_debounce #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .btn_raw   (btn_raw),
    .sw_raw    (sw_raw),
    .clear     (clear),
    .data      (data),
    .trig      (trig),
    .pressed   (pressed),
    .press_cnt (press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every trig must match the oldest queued expectation.
  initial prev_trig = 1'b0;
  always @(negedge clk) begin
    if (trig === 1'b1) begin
      checks++;
      if (prev_trig === 1'b1) begin
        errors++;
        $display("FAIL trig_width: trig high two cycles in a row at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_trig: trig at cycle %0d with none expected", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checks += 3;
        if (data !== mon_e.d) begin
          errors++;
          $display("FAIL trig_data: got %b expected %b at cycle %0d", data, mon_e.d, cyc);
        end
        if (press_cnt !== mon_e.c) begin
          errors++;
          $display("FAIL trig_press_cnt: got %0d expected %0d at cycle %0d", press_cnt, mon_e.c, cyc);
        end
        if (cyc !== mon_e.at) begin
          errors++;
          $display("FAIL trig_latency: trig at cycle %0d expected %0d", cyc, mon_e.at);
        end
        $display("trig cycle %0d data %b press_cnt %0d", cyc, data, press_cnt);
      end
    end
    prev_trig = trig;
  end

  // Drive one clean press (bit value expected from the filtered switch) and release.
  task automatic do_press(input logic exp_d);
    exp_t e;
    btn_raw   = 1'b1;
    model_cnt = model_cnt + 8'd1;
    e.d  = exp_d;
    e.c  = model_cnt;
    e.at = cyc + DB + 2;
    exp_q.push_back(e);
    repeat (10) @(negedge clk);
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    checks += 4;
    if (data !== 1'b0)     begin errors++; $display("FAIL reset_data: got %b expected 0", data); end
    if (trig !== 1'b0)     begin errors++; $display("FAIL reset_trig: got %b expected 0", trig); end
    if (pressed !== 1'b0)  begin errors++; $display("FAIL reset_pressed: got %b expected 0", pressed); end
    if (press_cnt !== 8'd0) begin errors++; $display("FAIL reset_press_cnt: got %0d expected 0", press_cnt); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks += 2;
    if (pressed !== 1'b0)  begin errors++; $display("FAIL idle_pressed: got %b expected 0", pressed); end
    if (press_cnt !== 8'd0) begin errors++; $display("FAIL idle_press_cnt: got %0d expected 0", press_cnt); end
    $display("reset done");
  endtask

  task automatic test_clean_press;
    exp_t e;
    sw_raw = 1'b1;
    repeat (12) @(negedge clk);
    btn_raw   = 1'b1;
    model_cnt = model_cnt + 8'd1;
    e.d  = 1'b1;
    e.c  = model_cnt;
    e.at = cyc + DB + 2;
    exp_q.push_back(e);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 5) begin
        checks += 2;
        if (trig !== 1'b0)    begin errors++; $display("FAIL early_trig: got %b expected 0", trig); end
        if (pressed !== 1'b0) begin errors++; $display("FAIL early_pressed: got %b expected 0", pressed); end
      end
      if (i == 6) begin
        checks++;
        if (pressed !== 1'b1) begin errors++; $display("FAIL pressed_on_trig: got %b expected 1", pressed); end
      end
      if (i == 7) begin
        checks += 2;
        if (trig !== 1'b0)    begin errors++; $display("FAIL trig_drop: got %b expected 0", trig); end
        if (press_cnt !== model_cnt) begin errors++; $display("FAIL clean_cnt: got %0d expected %0d", press_cnt, model_cnt); end
      end
    end
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);
    checks += 2;
    if (pressed !== 1'b0) begin errors++; $display("FAIL released_pressed: got %b expected 0", pressed); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL clean_missing_trig: %0d pending expected 0", exp_q.size()); end
    $display("clean press done press_cnt %0d", press_cnt);
  endtask

  task automatic test_press_bounce;
    logic [7:0] pat;
    pat = 8'b0111_0111;
    for (int i = 0; i < 16; i++) begin
      btn_raw = (i < 8) ? pat[i] : 1'b0;
      @(negedge clk);
      checks++;
      if (pressed !== 1'b0) begin errors++; $display("FAIL bounce_pressed: got %b expected 0 step %0d", pressed, i); end
    end
    checks++;
    if (press_cnt !== model_cnt) begin errors++; $display("FAIL bounce_cnt: got %0d expected %0d", press_cnt, model_cnt); end
    $display("press bounce done press_cnt %0d", press_cnt);
  endtask

  task automatic test_release_bounce;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_cnt = 8'd0;
    checks++;
    if (press_cnt !== 8'd0) begin errors++; $display("FAIL clear_cnt: got %0d expected 0", press_cnt); end
    do_press_hold();
    btn_raw = 1'b0;
    repeat (2) @(negedge clk);
    btn_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (pressed !== 1'b1) begin errors++; $display("FAIL rel_bounce_pressed: got %b expected 1 step %0d", pressed, i); end
    end
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);
    do_press(1'b1);
    checks += 2;
    if (press_cnt !== 8'd2) begin errors++; $display("FAIL rel_bounce_cnt: got %0d expected 2", press_cnt); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL rel_missing_trig: %0d pending expected 0", exp_q.size()); end
    $display("release bounce done press_cnt %0d", press_cnt);
  endtask

  // Press and keep holding (used where the scenario continues while pressed).
  task automatic do_press_hold;
    exp_t e;
    btn_raw   = 1'b1;
    model_cnt = model_cnt + 8'd1;
    e.d  = sw_raw;
    e.c  = model_cnt;
    e.at = cyc + DB + 2;
    exp_q.push_back(e);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_switch_filter;
    sw_raw = 1'b0;
    repeat (12) @(negedge clk);
    sw_raw = 1'b1;
    repeat (2) @(negedge clk);
    sw_raw = 1'b0;
    repeat (4) @(negedge clk);
    do_press(1'b0);
    sw_raw = 1'b1;
    repeat (10) @(negedge clk);
    do_press(1'b1);
    // Switch and button change together: the strobe sees the old filtered level.
    sw_raw = 1'b0;
    do_press(1'b1);
    do_press(1'b0);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL sw_missing_trig: %0d pending expected 0", exp_q.size()); end
    $display("switch filter done press_cnt %0d", press_cnt);
  endtask

  task automatic test_reset_mid_press;
    exp_t e;
    sw_raw  = 1'b1;
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (data !== 1'b0)      begin errors++; $display("FAIL rst_data: got %b expected 0", data); end
    if (trig !== 1'b0)      begin errors++; $display("FAIL rst_trig: got %b expected 0", trig); end
    if (pressed !== 1'b0)   begin errors++; $display("FAIL rst_pressed: got %b expected 0", pressed); end
    if (press_cnt !== 8'd0) begin errors++; $display("FAIL rst_press_cnt: got %0d expected 0", press_cnt); end
    repeat (3) @(negedge clk);
    checks += 2;
    if (pressed !== 1'b0)   begin errors++; $display("FAIL rst_hold_pressed: got %b expected 0", pressed); end
    if (press_cnt !== 8'd0) begin errors++; $display("FAIL rst_hold_cnt: got %0d expected 0", press_cnt); end
    rst_n     = 1'b1;
    model_cnt = 8'd1;
    e.d  = 1'b0;
    e.c  = 8'd1;
    e.at = cyc + DB + 2;
    exp_q.push_back(e);
    repeat (10) @(negedge clk);
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL rst_missing_trig: %0d pending expected 0", exp_q.size()); end
    $display("reset mid-press done press_cnt %0d", press_cnt);
  endtask

  task automatic test_counter_wrap;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_cnt = 8'd0;
    for (int i = 0; i < 255; i++) begin
      do_press(1'b1);
    end
    checks++;
    if (press_cnt !== 8'd255) begin errors++; $display("FAIL cnt_255: got %0d expected 255", press_cnt); end
    do_press(1'b1);
    checks++;
    if (press_cnt !== 8'd0) begin errors++; $display("FAIL cnt_wrap: got %0d expected 0", press_cnt); end
    $display("counter wrap done press_cnt %0d", press_cnt);
  endtask

  task automatic test_clear_on_trig;
    exp_t e;
    btn_raw   = 1'b1;
    model_cnt = 8'd0;
    e.d  = 1'b1;
    e.c  = 8'd0;
    e.at = cyc + DB + 2;
    exp_q.push_back(e);
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks += 2;
    if (trig !== 1'b1)      begin errors++; $display("FAIL clr_trig: got %b expected 1", trig); end
    if (press_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt: got %0d expected 0", press_cnt); end
    repeat (9) @(negedge clk);
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);
    do_press(1'b1);
    checks += 2;
    if (press_cnt !== 8'd1) begin errors++; $display("FAIL after_clr_cnt: got %0d expected 1", press_cnt); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL clr_missing_trig: %0d pending expected 0", exp_q.size()); end
    $display("clear on trig done press_cnt %0d", press_cnt);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_cnt = 8'd0;
    rst_n     = 1'b0;
    btn_raw   = 1'b0;
    sw_raw    = 1'b0;
    clear     = 1'b0;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_switch_filter();
    test_reset_mid_press();
    test_counter_wrap();
    test_clear_on_trig();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_entry_debounce.md
BIT_ENTRY_DEBOUNCE -- requirements
Module: bit_entry_debounce

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16, the number of consecutive stable synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port btn_raw, input, 1, the asynchronous mechanical push-button level; 1 = pressed.
REQ-005 SHALL have port sw_raw, input, 1, the asynchronous mechanical data-switch level.
REQ-006 SHALL have port clear, input, 1, a synchronous request to zero press_cnt.
REQ-007 SHALL have port data, output, 1, the registered bit value presented to the downstream pattern FSM.
REQ-008 SHALL have port trig, output, 1, a registered one-cycle strobe marking data as a new bit.
REQ-009 SHALL have port pressed, output, 1, the debounced button level.
REQ-010 SHALL have port press_cnt, output, 8, the count of accepted presses.

Function
REQ-011 SHALL pass btn_raw and sw_raw each through a 2-flop synchronizer; the outputs are btn_s and sw_s.
REQ-012 SHALL run a button FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a 16-bit counter cnt.
REQ-013 SHALL, in IDLE with btn_s=1, go to PRESS_WAIT with cnt=1; with btn_s=0, hold.
REQ-014 SHALL, in PRESS_WAIT with btn_s=0, return to IDLE with cnt=0 and no strobe.
REQ-015 SHALL, in PRESS_WAIT with btn_s=1 and cnt=DB_CYCLES-1, go to PRESSED and set trig=1 for exactly one cycle; otherwise cnt increments.
REQ-016 SHALL, in PRESSED with btn_s=0, go to RELEASE_WAIT with cnt=1; with btn_s=1, hold.
REQ-017 SHALL, in RELEASE_WAIT with btn_s=1, return to PRESSED with cnt=0 and no new trig.
REQ-018 SHALL, in RELEASE_WAIT with btn_s=0 and cnt=DB_CYCLES-1, go to IDLE; otherwise cnt increments.
REQ-019 SHALL drive pressed=1 in PRESSED and RELEASE_WAIT, and pressed=0 otherwise.
REQ-020 SHALL keep a debounced switch sw_db with its own 16-bit counter: clear the counter when sw_s=sw_db; increment it when they differ; when it reaches DB_CYCLES-1 while still differing, load sw_db<=sw_s and clear the counter.
REQ-021 SHALL, on the edge that sets trig, load data with the value of sw_db as it was before that edge; data SHALL hold between strobes.
REQ-022 SHALL give trig a latency of exactly DB_CYCLES+2 rising edges, counting the first edge that samples btn_raw=1, for a bounce-free press; the sw_db update latency SHALL be the same.
REQ-023 SHALL increment press_cnt by 1 on each trig, wrapping 255->0.
REQ-024 SHALL, when clear=1, set press_cnt=0 on the next edge; clear SHALL take priority over a simultaneous trig, which is still issued with press_cnt=0.
REQ-025 SHALL never produce two trig pulses without an intervening pass through IDLE.
REQ-026 SHALL never leave trig high for more than one cycle.

Reset
REQ-027 SHALL, while reset=0, immediately force synchronizers=0, state=IDLE, both counters=0, sw_db=0, data=0, trig=0, pressed=0 and press_cnt=0.
REQ-028 SHALL drop trig immediately if reset asserts in the trig cycle.
REQ-029 SHALL treat a button held through reset release as a new press, with trig DB_CYCLES+2 edges after the first post-release edge.

Verification (DB_CYCLES=4)
REQ-030 Clean press: sw_raw=1 stable for more than 10 cycles, then btn_raw rises and holds 20 cycles -> a single trig at the 6th edge with data=1, press_cnt=1 and pressed=1 from that edge.
REQ-031 Press bounce: btn_raw runs 1,1,1,0,1,1,1,0 (one cycle per value) and then stays 0 -> trig never asserts, pressed stays 0 and press_cnt is unchanged.
REQ-032 Release bounce: while PRESSED, btn_raw goes low 2 cycles then high again -> no second trig and pressed stays 1. Then a full release of 8 cycles followed by a clean press -> a second trig with press_cnt=2.
REQ-033 Switch filter: sw_raw glitches 0->1 for 2 cycles, then a press -> data=0. Then sw_raw=1 held 10 cycles, then a press -> data=1.
REQ-034 Reset mid-press: btn_raw held high, reset=0 asserted during PRESS_WAIT for 3 cycles -> all outputs 0 during reset, and trig at the 6th edge after reset release.
REQ-035 Counter boundaries: 255 presses give press_cnt=255 and the next press gives 0. clear asserted on the trig edge -> press_cnt=0 with trig=1.
